// File: rtl/mmu_l1tlb_refill.sv
// L1 TLB refill write controller: accepts PTW/L2 refills, picks a victim slot and commits one entry write.
// Optional MMU_L1TLB_REFILL_INVALID_FIRST_EN: fill invalid slots before consulting the PLRU replacement unit.
module mmu_l1tlb_refill #(
    parameter int VPN_W  = 20,
    parameter int PPN_W  = 20,
    parameter int ASID_W = 9,
    parameter int FLAG_W = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_refill_valid,
    output logic                                  o_refill_ready,
    input  logic [VPN_W-1:0]                      i_refill_vpn,
    input  logic [PPN_W-1:0]                      i_refill_ppn,
    input  logic [ASID_W-1:0]                     i_refill_asid,
    input  logic [FLAG_W-1:0]                     i_refill_flags,
    input  logic                                  i_refill_super,
    input  logic                                  i_flush,
    output logic [1:0]                            o_write_en_2,
    input  logic [4:0]                            i_write_position_5,
    output logic [31:0]                           o_normal_valid_32,
    output logic [3:0]                            o_super_valid_4,
    output logic                                  o_entry_we,
    output logic                                  o_entry_super,
    output logic [4:0]                            o_entry_idx_5,
    output logic [VPN_W+PPN_W+ASID_W+FLAG_W-1:0]  o_entry_data,
    output logic                                  o_refill_done
);

    localparam int DATA_W = VPN_W + PPN_W + ASID_W + FLAG_W;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        WRITE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [DATA_W-1:0]  data_q;
    logic               super_q;
    logic [4:0]         idx_q;
    logic [31:0]        normal_valid;
    logic [3:0]         super_valid;
    logic               accept;
    logic [4:0]         victim;
    logic [1:0]         write_en;

    assign o_refill_ready = (state == IDLE) && !i_flush && !rst;
    assign accept         = i_refill_valid && o_refill_ready;

`ifdef MMU_L1TLB_REFILL_INVALID_FIRST_EN
    logic        normal_free;
    logic [4:0]  normal_free_idx;
    logic        super_free;
    logic [1:0]  super_free_idx;

    // Scan downward so the last hit recorded is the lowest-index invalid slot.
    always_comb begin
        normal_free     = 1'b0;
        normal_free_idx = 5'd0;
        super_free      = 1'b0;
        super_free_idx  = 2'd0;
        for (int i = 31; i >= 0; i--) begin
            if (!normal_valid[i]) begin
                normal_free     = 1'b1;
                normal_free_idx = 5'(i);
            end
        end
        for (int j = 3; j >= 0; j--) begin
            if (!super_valid[j]) begin
                super_free     = 1'b1;
                super_free_idx = 2'(j);
            end
        end
    end
`endif

    always_comb begin
        write_en = super_q ? 2'b10 : 2'b01;
        victim   = super_q ? {3'b000, i_write_position_5[1:0]} : i_write_position_5;
`ifdef MMU_L1TLB_REFILL_INVALID_FIRST_EN
        // The replacement unit is only consulted once the target array is full.
        if (super_q) begin
            if (super_free) begin
                write_en = 2'b00;
                victim   = {3'b000, super_free_idx};
            end
        end else begin
            if (normal_free) begin
                write_en = 2'b00;
                victim   = normal_free_idx;
            end
        end
`endif
    end

    always_comb begin
        state_next    = state;
        o_write_en_2  = 2'b00;
        o_entry_we    = 1'b0;
        o_refill_done = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SELECT;
                end
            end
            SELECT: begin
                o_write_en_2 = write_en;
                state_next   = i_flush ? IDLE : WRITE;
            end
            WRITE: begin
                // A flush in the write cycle drops the commit entirely.
                o_entry_we    = !i_flush;
                o_refill_done = !i_flush;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            super_q <= 1'b0;
            idx_q   <= 5'd0;
        end else begin
            if (accept) begin
                data_q  <= {i_refill_vpn, i_refill_ppn, i_refill_asid, i_refill_flags};
                super_q <= i_refill_super;
            end
            if (state == SELECT) begin
                idx_q <= victim;
            end
        end
    end

    // Flush has priority over a same-cycle valid-bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            normal_valid <= '0;
            super_valid  <= '0;
        end else if (i_flush) begin
            normal_valid <= '0;
            super_valid  <= '0;
        end else if (state == WRITE) begin
            if (super_q) begin
                super_valid[idx_q[1:0]] <= 1'b1;
            end else begin
                normal_valid[idx_q] <= 1'b1;
            end
        end
    end

    assign o_normal_valid_32 = normal_valid;
    assign o_super_valid_4   = super_valid;
    assign o_entry_super     = super_q;
    assign o_entry_idx_5     = idx_q;
    assign o_entry_data      = data_q;

endmodule

// File: tb/tb_mmu_l1tlb_refill.sv
// Directed self-checking bench for mmu_l1tlb_refill; expectations follow MMU_L1TLB_REFILL_INVALID_FIRST_EN.
module tb_mmu_l1tlb_refill;

    logic         clk;
    logic         rst;
    logic         i_refill_valid;
    logic         o_refill_ready;
    logic [19:0]  i_refill_vpn;
    logic [19:0]  i_refill_ppn;
    logic [8:0]   i_refill_asid;
    logic [7:0]   i_refill_flags;
    logic         i_refill_super;
    logic         i_flush;
    logic [1:0]   o_write_en_2;
    logic [4:0]   i_write_position_5;
    logic [31:0]  o_normal_valid_32;
    logic [3:0]   o_super_valid_4;
    logic         o_entry_we;
    logic         o_entry_super;
    logic [4:0]   o_entry_idx_5;
    logic [56:0]  o_entry_data;
    logic         o_refill_done;

    int checks;
    int failures;

`ifdef MMU_L1TLB_REFILL_INVALID_FIRST_EN
    localparam logic [1:0]  FIRST_WEN   = 2'b00;
    localparam logic [4:0]  FIRST_IDX   = 5'd0;
    localparam logic [31:0] FIRST_VALID = 32'h1;
    localparam logic [1:0]  FILL_WEN    = 2'b00;
    localparam logic [1:0]  SUPER_WEN   = 2'b00;
    localparam logic [1:0]  FI_WEN      = 2'b00;
    localparam logic [4:0]  FI_IDX      = 5'd0;
    localparam logic [31:0] FI_VALID    = 32'h1;
    localparam logic [1:0]  VS_WEN      = 2'b00;
    localparam logic [4:0]  VS_IDX      = 5'd0;
    localparam logic [31:0] VS_VALID    = 32'h1;
    localparam logic [4:0]  B2B_IDX0    = 5'd0;
    localparam logic [4:0]  B2B_IDX1    = 5'd1;
    localparam logic [31:0] B2B_VALID   = 32'h3;
`else
    localparam logic [1:0]  FIRST_WEN   = 2'b01;
    localparam logic [4:0]  FIRST_IDX   = 5'd5;
    localparam logic [31:0] FIRST_VALID = 32'h20;
    localparam logic [1:0]  FILL_WEN    = 2'b01;
    localparam logic [1:0]  SUPER_WEN   = 2'b10;
    localparam logic [1:0]  FI_WEN      = 2'b01;
    localparam logic [4:0]  FI_IDX      = 5'd6;
    localparam logic [31:0] FI_VALID    = 32'h40;
    localparam logic [1:0]  VS_WEN      = 2'b01;
    localparam logic [4:0]  VS_IDX      = 5'd9;
    localparam logic [31:0] VS_VALID    = 32'h200;
    localparam logic [4:0]  B2B_IDX0    = 5'd12;
    localparam logic [4:0]  B2B_IDX1    = 5'd13;
    localparam logic [31:0] B2B_VALID   = 32'h3000;
`endif

    mmu_l1tlb_refill dut (
        .clk                (clk),
        .rst                (rst),
        .i_refill_valid     (i_refill_valid),
        .o_refill_ready     (o_refill_ready),
        .i_refill_vpn       (i_refill_vpn),
        .i_refill_ppn       (i_refill_ppn),
        .i_refill_asid      (i_refill_asid),
        .i_refill_flags     (i_refill_flags),
        .i_refill_super     (i_refill_super),
        .i_flush            (i_flush),
        .o_write_en_2       (o_write_en_2),
        .i_write_position_5 (i_write_position_5),
        .o_normal_valid_32  (o_normal_valid_32),
        .o_super_valid_4    (o_super_valid_4),
        .o_entry_we         (o_entry_we),
        .o_entry_super      (o_entry_super),
        .o_entry_idx_5      (o_entry_idx_5),
        .o_entry_data       (o_entry_data),
        .o_refill_done      (o_refill_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        i_flush = 1'b1;
        next_cycle();
        i_flush = 1'b0;
    endtask

    // Full accept/select/write/idle sequence; payload is scrambled after the accept cycle.
    task automatic run_refill(input logic [19:0] vpn, input logic [19:0] ppn, input logic [8:0] asid,
                              input logic [7:0] flags, input logic sup, input logic [4:0] pos,
                              output logic rdy, output logic [1:0] wen, output logic we,
                              output logic es, output logic [4:0] idx, output logic [56:0] data,
                              output int done_cnt);
        done_cnt       = 0;
        i_refill_valid = 1'b1;
        i_refill_vpn   = vpn;
        i_refill_ppn   = ppn;
        i_refill_asid  = asid;
        i_refill_flags = flags;
        i_refill_super = sup;
        #1;
        rdy = o_refill_ready;
        if (o_refill_done) done_cnt++;
        next_cycle();
        i_refill_valid     = 1'b0;
        i_refill_vpn       = ~vpn;
        i_refill_ppn       = ~ppn;
        i_refill_asid      = ~asid;
        i_refill_flags     = ~flags;
        i_refill_super     = ~sup;
        i_write_position_5 = pos;
        #1;
        wen = o_write_en_2;
        if (o_refill_done) done_cnt++;
        next_cycle();
        i_write_position_5 = 5'd0;
        #1;
        we   = o_entry_we;
        es   = o_entry_super;
        idx  = o_entry_idx_5;
        data = o_entry_data;
        if (o_refill_done) done_cnt++;
        next_cycle();
        #1;
        if (o_refill_done) done_cnt++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (o_refill_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready got=%b exp=0", o_refill_ready);
        end
        checks++;
        if ({o_normal_valid_32, o_super_valid_4} !== 36'h0) begin
            failures++;
            $display("[TB] FAIL reset_valid got=%h exp=0", {o_normal_valid_32, o_super_valid_4});
        end
        checks++;
        if ({o_entry_we, o_refill_done, o_write_en_2, o_entry_idx_5, o_entry_super} !== 10'h0 || o_entry_data !== 57'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got we=%b done=%b wen=%b idx=%h data=%h exp all 0",
                     o_entry_we, o_refill_done, o_write_en_2, o_entry_idx_5, o_entry_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (o_refill_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL release_ready got=%b exp=1", o_refill_ready);
        end
    endtask

    task automatic test_first_refill();
        logic rdy, we, es;
        logic [1:0] wen;
        logic [4:0] idx;
        logic [56:0] data;
        int dc;
        run_refill(20'h12345, 20'hABCDE, 9'h1A5, 8'hCF, 1'b0, 5'd5, rdy, wen, we, es, idx, data, dc);
        checks++;
        if (rdy !== 1'b1 || wen !== FIRST_WEN) begin
            failures++;
            $display("[TB] FAIL first_select got rdy=%b wen=%b exp rdy=1 wen=%b", rdy, wen, FIRST_WEN);
        end
        checks++;
        if (we !== 1'b1 || es !== 1'b0 || idx !== FIRST_IDX) begin
            failures++;
            $display("[TB] FAIL first_write got we=%b super=%b idx=%0d exp we=1 super=0 idx=%0d", we, es, idx, FIRST_IDX);
        end
        checks++;
        if (data !== {20'h12345, 20'hABCDE, 9'h1A5, 8'hCF}) begin
            failures++;
            $display("[TB] FAIL first_data got=%h exp=%h", data, {20'h12345, 20'hABCDE, 9'h1A5, 8'hCF});
        end
        checks++;
        if (dc != 1 || o_normal_valid_32 !== FIRST_VALID || o_refill_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL first_commit got done_cnt=%0d valid=%h rdy=%b exp done_cnt=1 valid=%h rdy=1",
                     dc, o_normal_valid_32, o_refill_ready, FIRST_VALID);
        end
    endtask

    task automatic test_fill_normal();
        logic rdy, we, es;
        logic [1:0] wen;
        logic [4:0] idx;
        logic [56:0] data;
        int dc;
        pulse_flush();
        for (int i = 0; i < 32; i++) begin
            run_refill(20'(i), 20'(i + 100), 9'(i), 8'h0F, 1'b0, 5'(i), rdy, wen, we, es, idx, data, dc);
            checks++;
            if (rdy !== 1'b1 || wen !== FILL_WEN || we !== 1'b1 || es !== 1'b0 || idx !== 5'(i) || dc != 1) begin
                failures++;
                $display("[TB] FAIL fill_entry_%0d got rdy=%b wen=%b we=%b super=%b idx=%0d done_cnt=%0d exp 1 %b 1 0 %0d 1",
                         i, rdy, wen, we, es, idx, dc, FILL_WEN, i);
            end
        end
        checks++;
        if (o_normal_valid_32 !== 32'hFFFF_FFFF) begin
            failures++;
            $display("[TB] FAIL fill_valid got=%h exp=ffffffff", o_normal_valid_32);
        end
        run_refill(20'hFEDCB, 20'h13579, 9'h0AA, 8'h55, 1'b0, 5'd7, rdy, wen, we, es, idx, data, dc);
        checks++;
        if (wen !== 2'b01 || we !== 1'b1 || idx !== 5'd7) begin
            failures++;
            $display("[TB] FAIL full_victim got wen=%b we=%b idx=%0d exp wen=01 we=1 idx=7", wen, we, idx);
        end
        checks++;
        if (o_normal_valid_32 !== 32'hFFFF_FFFF || data !== {20'hFEDCB, 20'h13579, 9'h0AA, 8'h55}) begin
            failures++;
            $display("[TB] FAIL full_rewrite got valid=%h data=%h exp valid=ffffffff data=%h",
                     o_normal_valid_32, data, {20'hFEDCB, 20'h13579, 9'h0AA, 8'h55});
        end
    endtask

    task automatic test_super();
        logic rdy, we, es;
        logic [1:0] wen;
        logic [4:0] idx;
        logic [56:0] data;
        int dc;
        pulse_flush();
        for (int i = 0; i < 4; i++) begin
            run_refill(20'(i + 7), 20'(i + 9), 9'(i), 8'hF0, 1'b1, {3'b101, 2'(i)}, rdy, wen, we, es, idx, data, dc);
            checks++;
            if (wen !== SUPER_WEN || we !== 1'b1 || es !== 1'b1 || idx !== 5'(i) || dc != 1) begin
                failures++;
                $display("[TB] FAIL super_fill_%0d got wen=%b we=%b super=%b idx=%0d done_cnt=%0d exp %b 1 1 %0d 1",
                         i, wen, we, es, idx, dc, SUPER_WEN, i);
            end
        end
        checks++;
        if (o_super_valid_4 !== 4'hF || o_normal_valid_32 !== 32'h0) begin
            failures++;
            $display("[TB] FAIL super_valid got super=%h normal=%h exp super=f normal=0", o_super_valid_4, o_normal_valid_32);
        end
        run_refill(20'h00ABC, 20'h00DEF, 9'h001, 8'h81, 1'b1, 5'd2, rdy, wen, we, es, idx, data, dc);
        checks++;
        if (wen !== 2'b10 || es !== 1'b1 || idx !== 5'd2 || we !== 1'b1 || o_super_valid_4 !== 4'hF) begin
            failures++;
            $display("[TB] FAIL super_full_victim got wen=%b super=%b idx=%0d we=%b valid=%h exp 10 1 2 1 f",
                     wen, es, idx, we, o_super_valid_4);
        end
    endtask

    task automatic test_flush_select();
        i_refill_valid = 1'b1;
        i_refill_super = 1'b0;
        i_refill_vpn   = 20'h11111;
        next_cycle();
        i_refill_valid     = 1'b0;
        i_flush            = 1'b1;
        i_write_position_5 = 5'd3;
        next_cycle();
        i_flush            = 1'b0;
        i_write_position_5 = 5'd0;
        #1;
        checks++;
        if (o_entry_we !== 1'b0 || o_refill_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_select_abort got we=%b done=%b exp 0 0", o_entry_we, o_refill_done);
        end
        checks++;
        if (o_normal_valid_32 !== 32'h0 || o_super_valid_4 !== 4'h0 || o_refill_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_select_state got normal=%h super=%h rdy=%b exp 0 0 1",
                     o_normal_valid_32, o_super_valid_4, o_refill_ready);
        end
    endtask

    task automatic test_flush_write();
        i_refill_valid = 1'b1;
        i_refill_super = 1'b0;
        next_cycle();
        i_refill_valid     = 1'b0;
        i_write_position_5 = 5'd4;
        next_cycle();
        i_flush = 1'b1;
        #1;
        checks++;
        if (o_entry_we !== 1'b0 || o_refill_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_write_abort got we=%b done=%b exp 0 0", o_entry_we, o_refill_done);
        end
        next_cycle();
        i_flush = 1'b0;
        #1;
        checks++;
        if (o_normal_valid_32 !== 32'h0 || o_refill_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL flush_write_valid got valid=%h rdy=%b exp 0 1", o_normal_valid_32, o_refill_ready);
        end
    endtask

    task automatic test_flush_idle();
        i_refill_valid = 1'b1;
        i_refill_super = 1'b0;
        i_refill_vpn   = 20'h2468A;
        i_refill_ppn   = 20'h13579;
        i_refill_asid  = 9'h044;
        i_refill_flags = 8'h3C;
        i_flush        = 1'b1;
        #1;
        checks++;
        if (o_refill_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_idle_ready got=%b exp=0", o_refill_ready);
        end
        next_cycle();
        i_flush = 1'b0;
        #1;
        checks++;
        if (o_refill_ready !== 1'b1 || o_write_en_2 !== 2'b00) begin
            failures++;
            $display("[TB] FAIL flush_idle_no_accept got rdy=%b wen=%b exp 1 00", o_refill_ready, o_write_en_2);
        end
        next_cycle();
        i_refill_valid     = 1'b0;
        i_write_position_5 = 5'd6;
        #1;
        checks++;
        if (o_write_en_2 !== FI_WEN) begin
            failures++;
            $display("[TB] FAIL flush_idle_select got wen=%b exp=%b", o_write_en_2, FI_WEN);
        end
        next_cycle();
        i_write_position_5 = 5'd0;
        #1;
        checks++;
        if (o_entry_we !== 1'b1 || o_entry_idx_5 !== FI_IDX || o_entry_data !== {20'h2468A, 20'h13579, 9'h044, 8'h3C}) begin
            failures++;
            $display("[TB] FAIL flush_idle_commit got we=%b idx=%0d data=%h exp 1 %0d %h",
                     o_entry_we, o_entry_idx_5, o_entry_data, FI_IDX, {20'h2468A, 20'h13579, 9'h044, 8'h3C});
        end
        next_cycle();
        checks++;
        if (o_normal_valid_32 !== FI_VALID) begin
            failures++;
            $display("[TB] FAIL flush_idle_valid got=%h exp=%h", o_normal_valid_32, FI_VALID);
        end
    endtask

    task automatic test_victim_select();
        logic rdy, we, es;
        logic [1:0] wen;
        logic [4:0] idx;
        logic [56:0] data;
        int dc;
        pulse_flush();
        run_refill(20'h0BEEF, 20'h0CAFE, 9'h123, 8'hA5, 1'b0, 5'd9, rdy, wen, we, es, idx, data, dc);
        checks++;
        if (wen !== VS_WEN || we !== 1'b1 || idx !== VS_IDX || o_normal_valid_32 !== VS_VALID) begin
            failures++;
            $display("[TB] FAIL victim_select got wen=%b we=%b idx=%0d valid=%h exp %b 1 %0d %h",
                     wen, we, idx, o_normal_valid_32, VS_WEN, VS_IDX, VS_VALID);
        end
    endtask

    task automatic test_back_to_back();
        pulse_flush();
        i_refill_valid = 1'b1;
        i_refill_super = 1'b0;
        i_refill_vpn   = 20'hAAAAA;
        i_refill_ppn   = 20'h55555;
        i_refill_asid  = 9'h0F0;
        i_refill_flags = 8'h11;
        #1;
        checks++;
        if (o_refill_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_ready0 got=%b exp=1", o_refill_ready);
        end
        next_cycle();
        i_refill_vpn       = 20'hBBBBB;
        i_refill_ppn       = 20'h66666;
        i_refill_asid      = 9'h00F;
        i_refill_flags     = 8'h22;
        i_write_position_5 = 5'd12;
        #1;
        checks++;
        if (o_refill_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_ready_select got=%b exp=0", o_refill_ready);
        end
        next_cycle();
        i_write_position_5 = 5'd0;
        #1;
        checks++;
        if (o_entry_we !== 1'b1 || o_entry_idx_5 !== B2B_IDX0 || o_refill_ready !== 1'b0 ||
            o_entry_data !== {20'hAAAAA, 20'h55555, 9'h0F0, 8'h11}) begin
            failures++;
            $display("[TB] FAIL b2b_write0 got we=%b idx=%0d rdy=%b data=%h exp 1 %0d 0 %h",
                     o_entry_we, o_entry_idx_5, o_refill_ready, o_entry_data, B2B_IDX0,
                     {20'hAAAAA, 20'h55555, 9'h0F0, 8'h11});
        end
        next_cycle();
        checks++;
        if (o_refill_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_ready1 got=%b exp=1", o_refill_ready);
        end
        next_cycle();
        i_refill_valid     = 1'b0;
        i_write_position_5 = 5'd13;
        next_cycle();
        i_write_position_5 = 5'd0;
        #1;
        checks++;
        if (o_entry_we !== 1'b1 || o_entry_idx_5 !== B2B_IDX1 || o_entry_data !== {20'hBBBBB, 20'h66666, 9'h00F, 8'h22}) begin
            failures++;
            $display("[TB] FAIL b2b_write1 got we=%b idx=%0d data=%h exp 1 %0d %h",
                     o_entry_we, o_entry_idx_5, o_entry_data, B2B_IDX1, {20'hBBBBB, 20'h66666, 9'h00F, 8'h22});
        end
        next_cycle();
        checks++;
        if (o_normal_valid_32 !== B2B_VALID) begin
            failures++;
            $display("[TB] FAIL b2b_valid got=%h exp=%h", o_normal_valid_32, B2B_VALID);
        end
    endtask

    initial begin
        checks             = 0;
        failures           = 0;
        rst                = 1'b1;
        i_refill_valid     = 1'b0;
        i_refill_vpn       = '0;
        i_refill_ppn       = '0;
        i_refill_asid      = '0;
        i_refill_flags     = '0;
        i_refill_super     = 1'b0;
        i_flush            = 1'b0;
        i_write_position_5 = '0;
        test_reset();
        test_first_refill();
        test_fill_normal();
        test_super();
        test_flush_select();
        test_flush_write();
        test_flush_idle();
        test_victim_select();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmu_l1tlb_refill.md
# mmu_l1tlb_refill

L1 TLB refill write controller. It accepts translated entries from the L2 TLB/PTW over a valid/ready handshake and picks a victim slot in the 32-entry normal array or the 4-entry superpage array. It drives the write enables of the L1 TLB PLRU replacement unit and consumes its victim position. It owns the entry valid bits and performs the one-cycle entry-array write.

## Interface
- VPN_W, 20, virtual page number width
- PPN_W, 20, physical page number width
- ASID_W, 9, address-space ID width
- FLAG_W, 8, permission/attribute flags width (V,R,W,X,U,G,A,D)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_refill_valid  in  1  refill entry offered
- o_refill_ready  out  1  refill accepted when valid&ready
- i_refill_vpn  in  VPN_W  entry VPN
- i_refill_ppn  in  PPN_W  entry PPN
- i_refill_asid  in  ASID_W  entry ASID
- i_refill_flags  in  FLAG_W  entry flags
- i_refill_super  in  1  1 = superpage entry, 0 = normal entry
- i_flush  in  1  single-cycle flush-all pulse
- o_write_en_2  out  2  to replacement unit; bit0 normal, bit1 super, at most one set
- i_write_position_5  in  5  victim from replacement unit, sampled while o_write_en_2 != 0
- o_normal_valid_32  out  32  normal entry valid bits
- o_super_valid_4  out  4  super entry valid bits
- o_entry_we  out  1  entry-array write strobe
- o_entry_super  out  1  target array for the write
- o_entry_idx_5  out  5  target index (super uses [1:0], [4:2]=0)
- o_entry_data  out  VPN_W+PPN_W+ASID_W+FLAG_W  {vpn,ppn,asid,flags}
- o_refill_done  out  1  one-cycle pulse, entry committed

## Operation
- FSM states: IDLE, SELECT, WRITE.
- IDLE: o_refill_ready = 1 unless i_flush=1 or rst=1. On valid&ready, latch payload and super flag, go to SELECT.
- SELECT, one cycle: compute the victim per Configuration, latch the index, go to WRITE.
  - Victim for a normal entry: index 0..31.
  - Victim for a super entry: index 0..3 from i_write_position_5[1:0].
- WRITE, one cycle:
  - o_entry_we=1 with the latched index and data; o_refill_done=1.
  - Set the corresponding valid bit at the clock edge.
  - Go to IDLE.
- o_write_en_2 is asserted only in SELECT and only when the replacement unit is consulted. Bit chosen by the latched super flag.
- Flush: i_flush=1 clears all 36 valid bits at the next edge.
  - Flush in SELECT or WRITE aborts the refill: no o_entry_we, no o_refill_done, no valid-bit set, next state IDLE.
  - o_write_en_2 is still permitted in an aborted SELECT; the PLRU update is harmless.
- Flush in IDLE with i_refill_valid=1: ready=0, nothing accepted.
- Payload inputs are ignored outside the accept cycle.

## Timing
- Reset values: all registered outputs 0, valid bits 0, state IDLE. o_refill_ready=0 while rst high, 1 in the first cycle after release.
- Accept at edge T. SELECT during cycle T+1. WRITE (we, done) during cycle T+2. Ready high again in cycle T+3.
- Throughput: one refill per 3 cycles.
- o_write_en_2 and i_write_position_5 are combinational in the same SELECT cycle. The replacement unit updates its tree at the end of that cycle.
- Rewriting an already-valid slot keeps its valid bit at 1.
- A valid bit set in WRITE and a flush in the same cycle: the flush wins, bit reads 0.

## Configuration
- MMU_L1TLB_REFILL_INVALID_FIRST_EN defined:
  - SELECT picks the lowest-index invalid slot of the target array.
  - o_write_en_2 is asserted only if that array is full; victim = i_write_position_5.
- Undefined:
  - o_write_en_2 is always asserted in SELECT.
  - Victim = i_write_position_5 regardless of valid bits.

## Test plan
- Reset release, normal refill vpn=0x12345, macro defined, all invalid -> o_entry_we at T+2, idx=0, o_write_en_2=00, o_normal_valid_32=0x1, done pulse once.
- 32 normal refills, then a 33rd with i_write_position_5=7 -> SELECT shows o_write_en_2=01, write idx=7, valid stays 0xFFFFFFFF.
- Super refill with 4 super valid, i_write_position_5=5'd2 -> o_write_en_2=10, o_entry_super=1, idx=2.
- i_flush pulse in the SELECT cycle of a refill -> no o_entry_we, no done, all valid bits 0 next cycle, ready back high the following cycle.
- i_flush and i_refill_valid in the same IDLE cycle -> ready=0, no accept. Same payload accepted the next cycle, committed 2 cycles later.
- Macro undefined, empty arrays, normal refill with i_write_position_5=9 -> o_write_en_2=01, write idx=9, valid=0x200.
